sram_port_arbiter: RTL and testbench

Shares the core's single-port SRAM (active-low cen/wen/ben, 1-cycle read latency) between two requesters: the core data port (CORE) and a host/loader port (HOST, e.g. AHB-side preload or debug).
- Fixed priority to CORE, with anti-starvation promotion of HOST.
- Routes read data back to the requester that issued the read.
- Sits between the core/host request ports and the sram_* pins of top.

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_arb_prio_fsm.sv | 85 ++++++++
 rtl/sram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter (sram_port_arbiter).
package sram_arb_pkg;

  // Which requester owns the read data returning from the SRAM next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // Which requester wins when both request in the same cycle.
  typedef enum logic {
    PRIO_CORE = 1'b0,
    PRIO_HOST = 1'b1
  } prio_e;

  localparam logic [3:0]  SRAM_IDLE_BEN = 4'hF;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

  // The SRAM is word organised; drop the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/sram_arb_prio_fsm.sv
// Priority state machine for the SRAM arbiter: tracks how long HOST has been
// starved behind CORE and promotes HOST for a bounded burst of grants.
module sram_arb_prio_fsm
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned HOST_BURST = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic c_req,
  input  logic h_req,
  input  logic h_gnt,
  output logic host_prio
);

  localparam int unsigned BURST_W = (HOST_BURST < 2) ? 1 : $clog2(HOST_BURST + 1);
  localparam logic [7:0]         WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(HOST_BURST - 1);

  prio_e              state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               host_denied;

  // HOST asked and lost to CORE this cycle.
  assign host_denied = c_req & h_req & ~h_gnt;
  assign host_prio   = (state_q == PRIO_HOST);

  // State and counter registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= PRIO_CORE;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state: the denial that brings wait_cnt to MAX_WAIT promotes HOST at
  // that same edge, so wait_cnt never exceeds MAX_WAIT (saturation is implicit).
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      PRIO_CORE: begin
        if (host_denied) begin
          if (wait_cnt_q >= WAIT_LAST) begin
            state_d     = PRIO_HOST;
            wait_cnt_d  = '0;
            burst_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      PRIO_HOST: begin
        wait_cnt_d = '0;
        if (!h_req) begin
          state_d     = PRIO_CORE;
          burst_cnt_d = '0;
        end else if (h_gnt) begin
          if (burst_cnt_q >= BURST_LAST) begin
            state_d     = PRIO_CORE;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = PRIO_CORE;
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port (CORE/HOST) arbiter in front of a single-port, 1-cycle-latency
// SRAM. Grants are combinational; read data is steered back to the port that
// issued the read. Optional grant/conflict statistics: define SRAM_ARB_STATS_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned HOST_BURST = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [3:0]  c_be,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [3:0]  h_be,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [31:0] h_rdata,
  output logic        sram_cen,
  output logic        sram_wen,
  output logic [3:0]  sram_ben,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0] stat_core_gnt,
  output logic [31:0] stat_host_gnt,
  output logic [31:0] stat_conflict
`endif
);

  logic   host_prio;
  owner_e owner_q, owner_d;

  sram_arb_prio_fsm #(
    .MAX_WAIT  (MAX_WAIT),
    .HOST_BURST(HOST_BURST)
  ) u_prio_fsm (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .c_req    (c_req),
    .h_req    (h_req),
    .h_gnt    (h_gnt),
    .host_prio(host_prio)
  );

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (HRESETn) begin
      if (c_req && h_req) begin
        c_gnt = ~host_prio;
        h_gnt = host_prio;
      end else begin
        c_gnt = c_req;
        h_gnt = h_req;
      end
    end
  end

  // SRAM command mux: winner drives the pins, otherwise the bus idles.
  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_ben  = SRAM_IDLE_BEN;
    sram_addr = '0;
    sram_din  = '0;
    owner_d   = OWN_NONE;
    if (c_gnt) begin
      sram_cen  = 1'b0;
      sram_wen  = ~c_we;
      sram_ben  = ~c_be;
      sram_addr = word_align(c_addr);
      sram_din  = c_wdata;
      owner_d   = c_we ? OWN_NONE : OWN_CORE;
    end else if (h_gnt) begin
      sram_cen  = 1'b0;
      sram_wen  = ~h_we;
      sram_ben  = ~h_be;
      sram_addr = word_align(h_addr);
      sram_din  = h_wdata;
      owner_d   = h_we ? OWN_NONE : OWN_HOST;
    end
  end

  // Remember who issued this cycle's read so its data can be returned next cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Read return: gating with HRESETn drops a response that lands in a reset cycle.
  always_comb begin
    c_rvalid = HRESETn && (owner_q == OWN_CORE);
    h_rvalid = HRESETn && (owner_q == OWN_HOST);
    c_rdata  = c_rvalid ? sram_dout : '0;
    h_rdata  = h_rvalid ? sram_dout : '0;
  end

`ifdef SRAM_ARB_STATS_EN
  logic [2:0]  stat_inc;
  logic [31:0] stat_q [3];

  assign stat_inc = {c_req & h_req, h_gnt, c_gnt};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      // Saturating event counter.
      always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
          stat_q[gi] <= '0;
        end else if (stat_inc[gi] && (stat_q[gi] != 32'hFFFF_FFFF)) begin
          stat_q[gi] <= stat_q[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign stat_core_gnt = stat_q[0];
  assign stat_host_gnt = stat_q[1];
  assign stat_conflict = stat_q[2];
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model (winner rule, starvation
// counters, reference memory, pending read). Stats checked when
// SRAM_ARB_STATS_EN is defined.
module tb_sram_port_arbiter;

  localparam int MAX_WAIT   = 4;
  localparam int HOST_BURST = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, h_req = 1'b0, h_we = 1'b0;
  logic [3:0]  c_be = '0, h_be = '0;
  logic [31:0] c_addr = '0, c_wdata = '0, h_addr = '0, h_wdata = '0;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [31:0] c_rdata, h_rdata;
  logic        sram_cen, sram_wen;
  logic [3:0]  sram_ben;
  logic [31:0] sram_addr, sram_din;
  logic [31:0] sram_dout = '0;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_core_gnt, stat_host_gnt, stat_conflict;
  int unsigned m_sc, m_sh, m_scf;
  bit          stat_known = 1'b0;
`endif

  sram_port_arbiter #(
    .MAX_WAIT  (MAX_WAIT),
    .HOST_BURST(HOST_BURST)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_be     (c_be),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_be     (h_be),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .sram_cen (sram_cen),
    .sram_wen (sram_wen),
    .sram_ben (sram_ben),
    .sram_addr(sram_addr),
    .sram_din (sram_din),
    .sram_dout(sram_dout)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_core_gnt(stat_core_gnt),
    .stat_host_gnt(stat_host_gnt),
    .stat_conflict(stat_conflict)
`endif
  );

  always #5 HCLK = ~HCLK;

  // Behavioural single-port SRAM: active-low controls, 1-cycle read latency.
  bit [31:0] sram_mem [256];
  always @(posedge HCLK) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr[9:2]];
      end
    end
  end

  // Reference model state.
  bit [31:0]   ref_mem [256];
  bit          m_prom;          // HOST currently promoted
  int          m_denied;        // consecutive HOST denials
  int          m_burst;         // HOST grants in current promotion
  int          m_pend;          // 0 none, 1 core, 2 host read returning next cycle
  logic [31:0] m_pend_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive, check mid-cycle against the model, advance the model.
  task automatic do_cycle(input bit rst_n,
                          input bit creq, input bit cwe, input logic [3:0] cbe,
                          input logic [31:0] caddr, input logic [31:0] cwd,
                          input bit hreq, input bit hwe, input logic [3:0] hbe,
                          input logic [31:0] haddr, input logic [31:0] hwd);
    bit cw, hw;
    logic        e_cen, e_wen;
    logic [3:0]  e_ben;
    logic [31:0] e_addr, e_din;
    bit          e_crv, e_hrv;
    @(posedge HCLK);
    #1;
    HRESETn = rst_n;
    c_req = creq; c_we = cwe; c_be = cbe; c_addr = caddr; c_wdata = cwd;
    h_req = hreq; h_we = hwe; h_be = hbe; h_addr = haddr; h_wdata = hwd;
    #4;
    cw = 1'b0; hw = 1'b0;
    if (rst_n) begin
      cw = creq && !(hreq && m_prom);
      hw = hreq && !cw;
    end
    e_cen = 1'b1; e_wen = 1'b1; e_ben = 4'hF; e_addr = '0; e_din = '0;
    if (cw) begin
      e_cen = 1'b0; e_wen = !cwe; e_ben = ~cbe; e_addr = {caddr[31:2], 2'b00}; e_din = cwd;
    end else if (hw) begin
      e_cen = 1'b0; e_wen = !hwe; e_ben = ~hbe; e_addr = {haddr[31:2], 2'b00}; e_din = hwd;
    end
    e_crv = rst_n && (m_pend == 1);
    e_hrv = rst_n && (m_pend == 2);
    check_eq("c_gnt", c_gnt, cw);
    check_eq("h_gnt", h_gnt, hw);
    check_eq("sram_cen", sram_cen, e_cen);
    check_eq("sram_wen", sram_wen, e_wen);
    check_eq("sram_ben", sram_ben, e_ben);
    check_eq("sram_addr", sram_addr, e_addr);
    check_eq("sram_din", sram_din, e_din);
    check_eq("c_rvalid", c_rvalid, e_crv);
    check_eq("h_rvalid", h_rvalid, e_hrv);
    check_eq("c_rdata", c_rdata, e_crv ? m_pend_data : 32'h0);
    check_eq("h_rdata", h_rdata, e_hrv ? m_pend_data : 32'h0);
`ifdef SRAM_ARB_STATS_EN
    if (stat_known) begin
      check_eq("stat_core_gnt", stat_core_gnt, m_sc);
      check_eq("stat_host_gnt", stat_host_gnt, m_sh);
      check_eq("stat_conflict", stat_conflict, m_scf);
    end
`endif
    $display("cyc %0d rst_n=%0b c_req=%0b/we%0b h_req=%0b/we%0b -> c_gnt=%0b h_gnt=%0b c_rv=%0b h_rv=%0b",
             cyc, rst_n, creq, cwe, hreq, hwe, c_gnt, h_gnt, c_rvalid, h_rvalid);
    // Advance model to the state after this edge.
    if (!rst_n) begin
      m_prom = 1'b0; m_denied = 0; m_burst = 0; m_pend = 0;
`ifdef SRAM_ARB_STATS_EN
      m_sc = 0; m_sh = 0; m_scf = 0; stat_known = 1'b1;
`endif
    end else begin
      m_pend = 0;
      if (cw) begin
        if (cwe) ref_mem[caddr[9:2]] = merge_be(ref_mem[caddr[9:2]], cwd, cbe);
        else begin m_pend = 1; m_pend_data = ref_mem[caddr[9:2]]; end
      end else if (hw) begin
        if (hwe) ref_mem[haddr[9:2]] = merge_be(ref_mem[haddr[9:2]], hwd, hbe);
        else begin m_pend = 2; m_pend_data = ref_mem[haddr[9:2]]; end
      end
`ifdef SRAM_ARB_STATS_EN
      if (cw) m_sc++;
      if (hw) m_sh++;
      if (creq && hreq) m_scf++;
`endif
      if (!m_prom) begin
        if (hreq && !hw) begin
          m_denied++;
          if (m_denied >= MAX_WAIT) begin m_prom = 1'b1; m_denied = 0; m_burst = 0; end
        end else begin
          m_denied = 0;
        end
      end else begin
        if (hw) m_burst++;
        if (!hreq || m_burst >= HOST_BURST) begin m_prom = 1'b0; m_burst = 0; end
      end
    end
    cyc++;
  endtask

  task automatic idle(input bit rst_n);
    do_cycle(rst_n, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [11:0] pat;
    pat = 12'b1100_0011_0000;  // h_gnt expected at conflict cycles 4,5,10,11

    // Reset state.
    repeat (3) idle(0);
    idle(1);

    // CORE write then read back.
    do_cycle(1, 1, 1, 4'hF, 32'h10, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0, 32'h0);
    do_cycle(1, 1, 0, 4'hF, 32'h10, 32'h0,        0, 0, 4'h0, 32'h0, 32'h0);
    idle(1);
    check_eq("core_rd_cafe", c_rdata, 32'hCAFEF00D);

    // HOST partial-byte write over a known word.
    do_cycle(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF,    32'h20, 32'h11223344);
    do_cycle(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'b0010, 32'h21, 32'h0000AB00);
    check_eq("host_wr_ben", sram_ben, 4'b1101);
    do_cycle(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF,    32'h20, 32'h0);
    idle(1);
    check_eq("host_rd_merge", h_rdata, 32'h1122AB44);

    // Zero byte-enable access is still issued.
    do_cycle(1, 1, 1, 4'h0, 32'h13, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'h0);

    // Continuous conflict from reset: starvation promotion pattern and stats.
    idle(0);
    for (int i = 0; i < 12; i++) begin
      do_cycle(1, 1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0);
      check_eq("prio_pattern", h_gnt, pat[i]);
`ifdef SRAM_ARB_STATS_EN
      if (i == 10) begin
        check_eq("stat_conflict_10", stat_conflict, 32'd10);
        check_eq("stat_core_8", stat_core_gnt, 32'd8);
        check_eq("stat_host_2", stat_host_gnt, 32'd2);
      end
`endif
    end
    idle(1);

    // Alternating reads to distinct addresses, no bubbles.
    do_cycle(1, 1, 1, 4'hF, 32'h30, 32'hA0A0A0A0, 0, 0, 4'h0, 32'h0, 32'h0);
    do_cycle(1, 0, 0, 4'h0, 32'h0,  32'h0, 1, 1, 4'hF, 32'h34, 32'hB1B1B1B1);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) do_cycle(1, 1, 0, 4'hF, 32'h30, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      else            do_cycle(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h34, 32'h0);
    end
    idle(1);
    check_eq("alt_last_h_rdata", h_rdata, 32'hB1B1B1B1);

    // Reset the cycle after a granted CORE read.
    do_cycle(1, 1, 0, 4'hF, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    do_cycle(0, 1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0);
    check_eq("rst_rvalid_drop", c_rvalid, 1'b0);
    check_eq("rst_cen_idle", sram_cen, 1'b1);
    idle(1);
    check_eq("post_rst_rvalid", c_rvalid, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      int hp;
      bit rn, cr, hr;
      hp = ((i / 200) % 2 == 1) ? 90 : 50;
      rn = ($urandom_range(0, 99) != 0);
      cr = ($urandom_range(0, 99) < 60);
      hr = ($urandom_range(0, 99) < hp);
      do_cycle(rn, cr, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 63)), $urandom,
               hr, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 63)), $urandom);
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
